traffic_phase_timer: RTL
========================

# traffic_phase_timer

Upstream timing stage for the traffic-light controller. Divides the system clock into a 1-second tick and counts per-phase durations for GREEN, YELLOW and RED. It emits a one-cycle `advance` strobe that the light-sequencing FSM uses as its step enable. It also latches pedestrian requests and cuts GREEN short once a minimum green time has elapsed.

## Interface
- `TICK_DIV`, 50_000_000, clock cycles per tick (1 s at 50 MHz); benches use 4.
- `GREEN_S`, 10, GREEN duration in ticks, range 1..2^CNT_W.
- `YELLOW_S`, 3, YELLOW duration in ticks, range 1..2^CNT_W.
- `RED_S`, 10, RED duration in ticks, range 1..2^CNT_W.
- `MIN_GREEN_S`, 4, minimum GREEN ticks before a pedestrian cut, range 1..GREEN_S.
- `CNT_W`, 8, width of `sec_left`.
- `clk`, in, 1, system clock.
- `reset`, in, 1, synchronous, active-high.
- `enable`, in, 1, run/freeze. When 0, the prescaler and all state hold.
- `ped_req`, in, 1, pedestrian request, already synchronised to `clk`. Any high cycle registers a request.
- `tick`, out, 1, one-cycle pulse, once per `TICK_DIV` enabled cycles.
- `advance`, out, 1, one-cycle strobe on a phase change.
- `phase`, out, 2, current phase: DEF=00, GREEN=01, YELLOW=10, RED=11.
- `sec_left`, out, CNT_W, ticks remaining in the current phase minus one.
- `ped_pending`, out, 1, pedestrian request latched and not yet served.

## Operation
- **Reset values:** `phase`=DEF, `sec_left`=0, `tick`=0, `advance`=0, `ped_pending`=0, prescaler=0. Reset overrides everything, including mid-phase.
- **Prescaler:** counts 0..TICK_DIV-1 while `enable`=1 and wraps to 0. The cycle after it holds TICK_DIV-1, `tick` is 1.
- **Phase sequence:** DEF→GREEN→YELLOW→RED→GREEN. DEF occurs only after reset and lasts until the first tick.
- **Advance condition, evaluated on each tick.** Advance occurs if either holds:
  - `sec_left`==0; or
  - `phase`==GREEN, `ped_pending`=1 and `sec_left` ≤ GREEN_S−MIN_GREEN_S.
- **On advance:** `phase` takes the next value and `sec_left` loads the new phase's duration − 1. DEF→GREEN loads GREEN_S−1.
- **On a tick without advance:** `sec_left` decrements by 1. It never underflows, because 0 always advances.
- **`ped_pending`:**
  - Set by `ped_req`=1 in any phase.
  - Cleared on the GREEN→YELLOW advance.
  - If `ped_req`=1 in the same cycle as that clear, set wins.
  - A request registered in the same cycle as a tick is first evaluated at the following tick.
- **Arithmetic:**
  - Compare against GREEN_S−MIN_GREEN_S as a CNT_W-bit constant.
  - The prescaler is $clog2(TICK_DIV) bits wide, minimum 1.
  - Out-of-range parameters are an elaboration error.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- `tick` and `advance` are asserted in the same cycle. `phase` and `sec_left` already hold their post-advance values in that cycle. The downstream FSM steps on `advance`=1.
- **Phase length:** GREEN, YELLOW and RED last exactly duration×TICK_DIV cycles when no pedestrian cut occurs.
- **Pedestrian-cut GREEN:** lasts max(MIN_GREEN_S, k)×TICK_DIV cycles, where k is the first tick after the request is latched.
- **First tick:** `tick` first rises TICK_DIV cycles after `reset` falls, assuming `enable`=1.
- **`enable` deasserted:** no ticks. Prescaler, `phase`, `sec_left` and `ped_pending` hold, but `ped_pending` can still be set. Counting resumes from the held prescaler value.

## Structure
- Shared package `traffic_pkg`:
  - `phase_t` (2-bit) and the constants `PH_DEF`, `PH_GREEN`, `PH_YELLOW`, `PH_RED`.
  - Function `next_phase(phase_t)`.
  - The same package is used by the light FSM so the encodings match.
- Sub-module `tick_prescaler` (params `TICK_DIV`; ports `clk`, `reset`, `enable`, `tick`). The phase counter and pedestrian logic live in the top module.

## Test plan
All scenarios use TICK_DIV=4, GREEN_S=5, YELLOW_S=2, RED_S=4, MIN_GREEN_S=2, `enable`=1.
- **Reset release and normal cycle.**
  - Stimulus: release reset at cycle 0.
  - Required: first `tick`/`advance` at cycle 4 with `phase`=01, `sec_left`=4.
  - Then YELLOW at cycle 24 (`sec_left`=1), RED at cycle 32 (`sec_left`=3), GREEN at cycle 48.
  - Period is 44 cycles thereafter.
- **Early pedestrian request.**
  - Stimulus: `ped_req` pulse the cycle after GREEN entry.
  - Required: `ped_pending`=1 next cycle. GREEN→YELLOW `advance` occurs 2 ticks (8 cycles) after entry. `ped_pending`=0 in that advance cycle.
- **Request during RED.**
  - Stimulus: `ped_req` pulse while `phase`=RED.
  - Required: `ped_pending` stays 1 through RED. The following GREEN lasts exactly 8 cycles.
- **Set wins over clear.**
  - Stimulus: `ped_req`=1 in the cycle of the GREEN→YELLOW advance.
  - Required: `ped_pending` stays 1, and the next GREEN is shortened.
- **Freeze.**
  - Stimulus: `enable`=0 for 20 cycles during YELLOW.
  - Required: no `tick`, and `sec_left`/`phase` unchanged. After re-enable, the next tick arrives after the remaining prescaler count.
- **Reset mid-operation.**
  - Stimulus: assert `reset` for 1 cycle in RED with `ped_pending`=1.
  - Required: next cycle `phase`=00, `sec_left`=0, `ped_pending`=0, `tick`=`advance`=0. First `tick` comes 4 cycles after reset falls.

Source files
------------

// File: rtl/traffic_phase_timer_pkg.sv
// Shared phase encoding for the traffic-light timing stage and the light FSM.
// Keeping both sides on one package guarantees the phase codes match.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_DEF    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_RED    = 2'b11
    } phase_t;

    // DEF exists only after reset; the running cycle is GREEN -> YELLOW -> RED -> GREEN.
    function automatic phase_t next_phase(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH_DEF:    nxt = PH_GREEN;
            PH_GREEN:  nxt = PH_YELLOW;
            PH_YELLOW: nxt = PH_RED;
            default:   nxt = PH_GREEN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/traffic_phase_timer_tick_prescaler.sv
// Free-running divider: counts enabled cycles 0..TICK_DIV-1 and strobes on the wrap.
// The strobe is combinational so the parent can register it alongside the phase update.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Per-phase duration counter with pedestrian-request shortening of GREEN.
// tick/advance/phase/sec_left all update on the same edge, so consumers see post-advance state.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned GREEN_S     = 10,
    parameter int unsigned YELLOW_S    = 3,
    parameter int unsigned RED_S       = 10,
    parameter int unsigned MIN_GREEN_S = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ped_req,
    output logic             tick,
    output logic             advance,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] sec_left,
    output logic             ped_pending
);

    if (TICK_DIV < 1 || CNT_W < 1 || CNT_W > 32 ||
        GREEN_S < 1 || 64'(GREEN_S) > (64'd1 << CNT_W) ||
        YELLOW_S < 1 || 64'(YELLOW_S) > (64'd1 << CNT_W) ||
        RED_S < 1 || 64'(RED_S) > (64'd1 << CNT_W) ||
        MIN_GREEN_S < 1 || MIN_GREEN_S > GREEN_S) begin : g_param_check
        $error("traffic_phase_timer: parameter out of range");
    end

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_S - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_S - 1);
    localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_S - 1);
    localparam logic [CNT_W-1:0] CUT_TH    = CNT_W'(GREEN_S - MIN_GREEN_S);

    logic tick_strobe;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .tick  (tick_strobe)
    );

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] sec_left_q, sec_left_d;
    logic             tick_q, tick_d;
    logic             advance_q, advance_d;
    logic             ped_pending_q, ped_pending_d;
    logic             advance_now;
    logic             ped_clr;

    always_comb begin
        phase_d     = phase_q;
        sec_left_d  = sec_left_q;
        tick_d      = tick_strobe;
        advance_d   = 1'b0;
        advance_now = 1'b0;
        ped_clr     = 1'b0;

        if (tick_strobe) begin
            // sec_left <= GREEN_S-MIN_GREEN_S means at least MIN_GREEN_S ticks of GREEN have elapsed
            advance_now = (sec_left_q == '0) ||
                          (phase_q == PH_GREEN && ped_pending_q && sec_left_q <= CUT_TH);
            if (advance_now) begin
                advance_d = 1'b1;
                phase_d   = next_phase(phase_q);
                ped_clr   = (phase_q == PH_GREEN);
                case (phase_d)
                    PH_GREEN:  sec_left_d = GREEN_LD;
                    PH_YELLOW: sec_left_d = YELLOW_LD;
                    PH_RED:    sec_left_d = RED_LD;
                    default:   sec_left_d = '0;
                endcase
            end else begin
                sec_left_d = sec_left_q - CNT_W'(1);
            end
        end

        // a new request in the clearing cycle keeps the latch set
        ped_pending_d = ped_req | (ped_pending_q & ~ped_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= PH_DEF;
            sec_left_q    <= '0;
            tick_q        <= 1'b0;
            advance_q     <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            sec_left_q    <= sec_left_d;
            tick_q        <= tick_d;
            advance_q     <= advance_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    assign tick        = tick_q;
    assign advance     = advance_q;
    assign phase       = phase_q;
    assign sec_left    = sec_left_q;
    assign ped_pending = ped_pending_q;

endmodule
